// File: rtl/irq_ctrl_if.sv
// Register bus between the core's I/O decoder and the interrupt controller.
interface irq_ctrl_if;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 16;

   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;

   modport master (output bus_addr, output bus_wr, output bus_wdata, input bus_rdata);
   modport slave  (input bus_addr, input bus_wr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: pending/mask/edge registers, single
// request line to the core, in-service tracking until software writes EOI.
module irq_ctrl #(
   parameter int unsigned N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src,
   input  logic             irq_en,
   output logic             irq_out,
   irq_ctrl_if.slave        bus
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned PAD_W  = DATA_W - 2 - ID_W;

   localparam logic [2:0] A_PENDING = 3'd0;
   localparam logic [2:0] A_MASK    = 3'd1;
   localparam logic [2:0] A_EDGE    = 3'd2;
   localparam logic [2:0] A_VECTOR  = 3'd3;
   localparam logic [2:0] A_EOI     = 3'd4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SVC  = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [N_SRC-1:0]  pending, pending_nxt;
   logic [N_SRC-1:0]  mask, edge_cfg, src_prev;
   logic [N_SRC-1:0]  active, edge_set;
   logic [DATA_W-1:0] vector;
   logic [ID_W-1:0]   sel;
   logic              wr_pending, wr_mask, wr_edge, wr_eoi;
   logic              accept, eoi;

   assign wr_pending = bus.bus_wr && (bus.bus_addr == A_PENDING);
   assign wr_mask    = bus.bus_wr && (bus.bus_addr == A_MASK);
   assign wr_edge    = bus.bus_wr && (bus.bus_addr == A_EDGE);
   assign wr_eoi     = bus.bus_wr && (bus.bus_addr == A_EOI);

   assign active   = pending & mask;
   assign edge_set = src & ~src_prev;
   assign accept   = (state == ST_REQ) && irq_en;
   assign eoi      = wr_eoi && (state == ST_SVC);

   // Fixed priority select: lowest active index wins.
   always_comb begin
      sel = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (active[i]) sel = ID_W'(i);
      end
   end

   // Next pending: level tracks src, edge latches rising edges until W1C or acceptance.
   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (edge_cfg[i]) begin
            if (edge_set[i]) begin
               pending_nxt[i] = 1'b1;
            end else if ((wr_pending && bus.bus_wdata[i]) ||
                         (accept && active[i] && (sel == ID_W'(i)))) begin
               pending_nxt[i] = 1'b0;
            end
         end else begin
            pending_nxt[i] = src[i];
         end
         if (wr_edge && (bus.bus_wdata[i] != edge_cfg[i])) pending_nxt[i] = 1'b0;
      end
   end

   // Request state machine next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (active != '0) state_nxt = ST_REQ;
         ST_REQ: begin
            if (irq_en)              state_nxt = ST_SVC;
            else if (active == '0)   state_nxt = ST_IDLE;
         end
         ST_SVC:  if (eoi) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered request line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         irq_out <= 1'b0;
      end else begin
         state   <= state_nxt;
         irq_out <= (state_nxt == ST_REQ);
      end
   end

   // Software-visible registers and in-service vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         mask     <= '0;
         edge_cfg <= '0;
         vector   <= '0;
         src_prev <= '0;
      end else begin
         pending  <= pending_nxt;
         src_prev <= src;
         if (wr_mask) mask <= bus.bus_wdata[N_SRC-1:0];
         if (wr_edge) edge_cfg <= bus.bus_wdata[N_SRC-1:0];
         if (accept) begin
            if (active != '0) vector <= {2'b10, {PAD_W{1'b0}}, sel};
            else              vector <= {2'b11, {(DATA_W-2){1'b0}}};
         end else if (eoi) begin
            vector[15:14] <= 2'b00;
         end
      end
   end

   // Combinational read mux.
   always_comb begin
      bus.bus_rdata = '0;
      case (bus.bus_addr)
         A_PENDING: bus.bus_rdata = DATA_W'(pending);
         A_MASK:    bus.bus_rdata = DATA_W'(mask);
         A_EDGE:    bus.bus_rdata = DATA_W'(edge_cfg);
         A_VECTOR:  bus.bus_rdata = vector;
         default:   bus.bus_rdata = '0;
      endcase
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model.
module tb_irq_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] src = '0;
   logic       irq_en = 1'b0;
   logic       irq_out;
   int         n_checks = 0;
   int         n_fail = 0;

   irq_ctrl_if bus();

   irq_ctrl #(.N_SRC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .src     (src),
      .irq_en  (irq_en),
      .irq_out (irq_out),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model: state 0=idle, 1=requesting, 2=in service.
   int          m_state;
   logic [7:0]  m_pend, m_mask, m_edge, m_prev;
   logic [15:0] m_vec;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return {8'h00, m_pend};
         3'd1: return {8'h00, m_mask};
         3'd2: return {8'h00, m_edge};
         3'd3: return m_vec;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin : ref_model
      logic [7:0] act, np;
      int         s;
      bit         w0, w1, w2, w4;
      if (rst) begin
         m_state = 0; m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_vec = '0;
      end else begin
         act = m_pend & m_mask;
         s   = lowest(act);
         w0  = bus.bus_wr && bus.bus_addr == 3'd0;
         w1  = bus.bus_wr && bus.bus_addr == 3'd1;
         w2  = bus.bus_wr && bus.bus_addr == 3'd2;
         w4  = bus.bus_wr && bus.bus_addr == 3'd4;
         np  = m_pend;
         for (int i = 0; i < 8; i++) begin
            if (!m_edge[i])                              np[i] = src[i];
            else if (src[i] && !m_prev[i])               np[i] = 1'b1;
            else if (w0 && bus.bus_wdata[i])             np[i] = 1'b0;
            else if (m_state == 1 && irq_en && s == i)   np[i] = 1'b0;
            if (w2 && bus.bus_wdata[i] != m_edge[i])     np[i] = 1'b0;
         end
         case (m_state)
            0: if (act != 0) m_state = 1;
            1: begin
               if (irq_en) begin
                  m_vec   = (s >= 0) ? (16'h8000 | 16'(s)) : 16'hC000;
                  m_state = 2;
               end else if (act == 0) m_state = 0;
            end
            default: if (w4) begin m_vec[15:14] = 2'b00; m_state = 0; end
         endcase
         if (w1) m_mask = bus.bus_wdata[7:0];
         if (w2) m_edge = bus.bus_wdata[7:0];
         m_prev = src;
         m_pend = np;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      bus.bus_addr = a; bus.bus_wdata = d; bus.bus_wr = 1'b1;
      step();
      bus.bus_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      bus.bus_addr = a;
      #1 d = bus.bus_rdata;
   endtask

   task automatic do_reset();
      src = '0; irq_en = 1'b0;
      bus.bus_wr = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
      rst = 1'b1; step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_reset();
      n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL reset_irq_out: got %b exp 0", irq_out); n_fail++; end
      for (int a = 0; a < 5; a++) begin
         bus_read(3'(a), d);
         n_checks++;
         if (d !== 16'h0000) begin $display("FAIL reset_reg%0d: got %h exp 0000", a, d); n_fail++; end
      end
   endtask

   task automatic test_edge_basic();
      logic [15:0] d;
      do_reset();
      bus_write(3'd1, 16'h0001); bus_write(3'd2, 16'h0001); irq_en = 1'b1;
      src = 8'h01; step(); src = 8'h00;
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0001) begin $display("FAIL edge_pend_t1: got %h exp 0001", d); n_fail++; end
      n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL edge_irq_t1: got %b exp 0", irq_out); n_fail++; end
      step(); n_checks++;
      if (irq_out !== 1'b1) begin $display("FAIL edge_irq_t2: got %b exp 1", irq_out); n_fail++; end
      step(); n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL edge_irq_t3: got %b exp 0", irq_out); n_fail++; end
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h8000) begin $display("FAIL edge_vector: got %h exp 8000", d); n_fail++; end
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0000) begin $display("FAIL edge_pend_t3: got %h exp 0000", d); n_fail++; end
      bus_write(3'd4, 16'hFFFF);
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h0000) begin $display("FAIL edge_eoi_vector: got %h exp 0000", d); n_fail++; end
   endtask

   task automatic test_level_priority();
      logic [15:0] d;
      do_reset();
      irq_en = 1'b1;
      bus_write(3'd1, 16'h0028);
      src = 8'h28;
      repeat (4) step();
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h8003) begin $display("FAIL level_first_vector: got %h exp 8003", d); n_fail++; end
      src = 8'h20; step(); step();
      bus_write(3'd4, 16'h0000);
      repeat (4) step();
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h8005) begin $display("FAIL level_second_vector: got %h exp 8005", d); n_fail++; end
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0020) begin $display("FAIL level_pending: got %h exp 0020", d); n_fail++; end
   endtask

   task automatic test_hold_and_spurious();
      logic [15:0] d;
      do_reset();
      bus_write(3'd2, 16'h0004); bus_write(3'd1, 16'h0004);
      src = 8'h04; step(); src = 8'h00;
      repeat (4) step();
      n_checks++;
      if (irq_out !== 1'b1) begin $display("FAIL hold_irq_out: got %b exp 1", irq_out); n_fail++; end
      bus_write(3'd1, 16'h0000);
      step(); n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL withdraw_irq_out: got %b exp 0", irq_out); n_fail++; end
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0004) begin $display("FAIL withdraw_pending: got %h exp 0004", d); n_fail++; end
      // Re-arm, then clear the only pending bit while the request is held.
      bus_write(3'd1, 16'h0004); step(); n_checks++;
      if (irq_out !== 1'b1) begin $display("FAIL rearm_irq_out: got %b exp 1", irq_out); n_fail++; end
      bus_write(3'd0, 16'h0004);
      irq_en = 1'b1; step(); irq_en = 1'b0;
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'hC000) begin $display("FAIL spurious_vector: got %h exp C000", d); n_fail++; end
      n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL spurious_irq_out: got %b exp 0", irq_out); n_fail++; end
      bus_write(3'd4, 16'h0000);
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h0000) begin $display("FAIL spurious_eoi_vector: got %h exp 0000", d); n_fail++; end
   endtask

   task automatic test_svc_accumulate();
      logic [15:0] d;
      do_reset();
      bus_write(3'd1, 16'h0003); bus_write(3'd2, 16'h0003); irq_en = 1'b1;
      src = 8'h02; step(); src = 8'h00;
      repeat (3) step();
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h8001) begin $display("FAIL svc_vector: got %h exp 8001", d); n_fail++; end
      irq_en = 1'b0;
      src = 8'h02; step(); src = 8'h00; step(); step();
      n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL svc_no_request: got %b exp 0", irq_out); n_fail++; end
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0002) begin $display("FAIL svc_pending: got %h exp 0002", d); n_fail++; end
      bus_write(3'd4, 16'h0000); step(); n_checks++;
      if (irq_out !== 1'b1) begin $display("FAIL svc_eoi_rerequest: got %b exp 1", irq_out); n_fail++; end
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h0001) begin $display("FAIL svc_eoi_vector: got %h exp 0001", d); n_fail++; end
   endtask

   task automatic test_priority_change();
      logic [15:0] d;
      do_reset();
      bus_write(3'd1, 16'h0012); bus_write(3'd2, 16'h0012);
      src = 8'h10; step(); src = 8'h00; step(); step();
      n_checks++;
      if (irq_out !== 1'b1) begin $display("FAIL prio_req: got %b exp 1", irq_out); n_fail++; end
      src = 8'h02; step(); src = 8'h00; step();
      irq_en = 1'b1; step(); irq_en = 1'b0;
      bus_read(3'd3, d); n_checks++;
      if (d !== 16'h8001) begin $display("FAIL prio_vector: got %h exp 8001", d); n_fail++; end
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0010) begin $display("FAIL prio_pending: got %h exp 0010", d); n_fail++; end
   endtask

   task automatic test_edge_cfg_change();
      logic [15:0] d;
      do_reset();
      src = 8'h40; step(); step();
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0040) begin $display("FAIL cfg_level_pending: got %h exp 0040", d); n_fail++; end
      bus_write(3'd2, 16'h0040); step();
      bus_read(3'd0, d); n_checks++;
      if (d !== 16'h0000) begin $display("FAIL cfg_change_clear: got %h exp 0000", d); n_fail++; end
      src = 8'h00;
   endtask

   task automatic test_reset_in_svc();
      logic [15:0] d;
      do_reset();
      bus_write(3'd1, 16'h0001); bus_write(3'd2, 16'h0001); irq_en = 1'b1;
      src = 8'h01; step(); src = 8'h00; repeat (3) step();
      src = 8'h80;
      rst = 1'b1; step(); rst = 1'b0;
      n_checks++;
      if (irq_out !== 1'b0) begin $display("FAIL rst_svc_irq_out: got %b exp 0", irq_out); n_fail++; end
      for (int a = 0; a < 4; a++) begin
         bus_read(3'(a), d); n_checks++;
         if (d !== 16'h0000) begin $display("FAIL rst_svc_reg%0d: got %h exp 0000", a, d); n_fail++; end
      end
      src = 8'h00; irq_en = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0] a;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 299) == 0);
         src         = src ^ 8'($urandom & $urandom & $urandom);
         irq_en      = ($urandom_range(0, 3) != 0);
         a           = 3'($urandom_range(0, 7));
         bus.bus_addr  = a;
         bus.bus_wr    = ($urandom_range(0, 5) == 0);
         bus.bus_wdata = 16'($urandom);
         #1;
         n_checks++;
         if (irq_out !== (m_state == 1)) begin
            $display("FAIL rand_irq_out cyc %0d: got %b exp %b", c, irq_out, m_state == 1); n_fail++;
         end
         n_checks++;
         if (bus.bus_rdata !== m_read(a)) begin
            $display("FAIL rand_rdata cyc %0d addr %0d: got %h exp %h", c, a, bus.bus_rdata, m_read(a)); n_fail++;
         end
         step();
      end
      rst = 1'b0; bus.bus_wr = 1'b0;
   endtask

   initial begin
      bus.bus_addr = '0; bus.bus_wr = 1'b0; bus.bus_wdata = '0;
      test_reset();
      test_edge_basic();
      test_level_priority();
      test_hold_and_spurious();
      test_svc_accumulate();
      test_priority_change();
      test_edge_cfg_change();
      test_reset_in_svc();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
